// File: rtl/logic_resp_checker_pkg.sv
// Shared types and golden model for the response checker of y = (a & b) | (c ^ d).
// Vectors are packed {a,b,c,d} with a in bit 3.
package logic_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_VEC = 16;

  function automatic logic logic_golden(input logic [3:0] vec);
    return (vec[3] & vec[2]) | (vec[1] ^ vec[0]);
  endfunction

endpackage

// File: rtl/logic_resp_checker_cov_tracker.sv
// Sticky coverage map of applied vectors; full_next looks ahead through the
// incoming set so the run can close on the edge that completes coverage.
module cov_tracker
  import logic_chk_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               set_en,
  input  logic [3:0]         set_idx,
  output logic [NUM_VEC-1:0] map,
  output logic               full_next
);

  logic [NUM_VEC-1:0] map_r;
  logic [NUM_VEC-1:0] set_mask_s;
  logic [NUM_VEC-1:0] merged_s;

  // One-hot of the incoming index merged with the stored map.
  always_comb begin
    set_mask_s = {NUM_VEC{1'b0}};
    if (set_en) begin
      set_mask_s[set_idx] = 1'b1;
    end else begin
      set_mask_s = {NUM_VEC{1'b0}};
    end
    merged_s  = map_r | set_mask_s;
    full_next = &merged_s;
  end

  // Map storage: clear wins over set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      map_r <= {NUM_VEC{1'b0}};
    end else if (clr) begin
      map_r <= {NUM_VEC{1'b0}};
    end else begin
      map_r <= merged_s;
    end
  end

  assign map = map_r;

endmodule

// File: rtl/logic_resp_checker.sv
// Receive-side checker: compares DUT samples against the golden function,
// tracks vector coverage, counts mismatches and reports a pass/fail verdict.
module logic_resp_checker
  import logic_chk_pkg::*;
#(
  parameter int ERR_W   = 8,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             smp_valid,
  input  logic [3:0]       smp_vec,
  input  logic             smp_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      cov_map,
  output logic             ff_valid,
  output logic [3:0]       ff_vec,
  output logic             ff_y
);

  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic [ERR_W-1:0] err_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic             timeout_r;
  logic             ff_valid_r;
  logic [3:0]       ff_vec_r;
  logic             ff_y_r;

  logic             start_acc_s;
  logic             sample_s;
  logic             exp_s;
  logic             mism_s;
  logic [ERR_W-1:0] err_next_s;
  logic             to_hit_s;
  logic             cov_full_s;
  logic [15:0]      cov_map_s;

  // Sample qualification, golden compare and saturating error update.
  always_comb begin
    start_acc_s = start && (state_r != ST_RUN);
    sample_s    = (state_r == ST_RUN) && smp_valid;
    exp_s       = logic_golden(smp_vec);
    // Case inequality so an X/Z response from the DUT counts as a mismatch.
    mism_s      = sample_s && (smp_y !== exp_s);
    to_hit_s    = (to_cnt_r == TO_LAST);
    if (mism_s && (err_r != ERR_MAX)) begin
      err_next_s = err_r + ERR_W'(1);
    end else begin
      err_next_s = err_r;
    end
  end

  cov_tracker u_cov (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (start_acc_s),
    .set_en    (sample_s),
    .set_idx   (smp_vec),
    .map       (cov_map_s),
    .full_next (cov_full_s)
  );

  // Run-control FSM with all result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      to_cnt_r   <= {TO_W{1'b0}};
      err_r      <= {ERR_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      timeout_r  <= 1'b0;
      ff_valid_r <= 1'b0;
      ff_vec_r   <= 4'd0;
      ff_y_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r    <= ST_RUN;
            to_cnt_r   <= {TO_W{1'b0}};
            err_r      <= {ERR_W{1'b0}};
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            timeout_r  <= 1'b0;
            ff_valid_r <= 1'b0;
            ff_vec_r   <= 4'd0;
            ff_y_r     <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN: begin
          err_r <= err_next_s;
          if (mism_s && !ff_valid_r) begin
            ff_valid_r <= 1'b1;
            ff_vec_r   <= smp_vec;
            ff_y_r     <= smp_y;
          end else begin
            ff_valid_r <= ff_valid_r;
          end
          // Coverage completion takes priority over an expiring timeout.
          if (cov_full_s) begin
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            pass_r    <= (err_next_s == {ERR_W{1'b0}});
            timeout_r <= 1'b0;
          end else if (to_hit_s) begin
            state_r   <= ST_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            pass_r    <= 1'b0;
            timeout_r <= 1'b1;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign timeout   = timeout_r;
  assign err_count = err_r;
  assign cov_map   = cov_map_s;
  assign ff_valid  = ff_valid_r;
  assign ff_vec    = ff_vec_r;
  assign ff_y      = ff_y_r;

endmodule

// File: tb/tb_logic_resp_checker.sv
// Scoreboard bench: each run's predicted verdict is queued at issue time and
// popped by an independent monitor when done rises.
module tb_logic_resp_checker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start, smp_valid, smp_y;
  logic [3:0]  smp_vec;
  logic        busy, done, pass, timeout, ff_valid, ff_y;
  logic [7:0]  err_count;
  logic [15:0] cov_map;
  logic [3:0]  ff_vec;

  logic        s1_start, s1_valid, s1_y;
  logic [3:0]  s1_vec;
  logic        b1, d1, p1, t1, fv1, fy1;
  logic [1:0]  e1;
  logic [15:0] c1;
  logic [3:0]  fvec1;

  logic_resp_checker u0 (
    .clock(clock), .reset_n(reset_n), .start(start), .smp_valid(smp_valid),
    .smp_vec(smp_vec), .smp_y(smp_y), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .cov_map(cov_map),
    .ff_valid(ff_valid), .ff_vec(ff_vec), .ff_y(ff_y)
  );

  logic_resp_checker #(.ERR_W(2), .TIMEOUT(64), .TO_W(7)) u1 (
    .clock(clock), .reset_n(reset_n), .start(s1_start), .smp_valid(s1_valid),
    .smp_vec(s1_vec), .smp_y(s1_y), .busy(b1), .done(d1), .pass(p1),
    .timeout(t1), .err_count(e1), .cov_map(c1),
    .ff_valid(fv1), .ff_vec(fvec1), .ff_y(fy1)
  );

  typedef struct {
    logic [7:0]  err;
    logic [15:0] cov;
    logic        pass;
    logic        tmo;
    logic        ffv;
    logic [3:0]  ffvec;
    logic        ffy;
    int          cycles;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t last_e;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  logic done_q = 1'b0;

  logic [3:0] sv[64];
  logic       sy[64];
  bit         sval[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit gold(input logic [3:0] v);
    bit a, b, c, d;
    {a, b, c, d} = v;
    return (a && b) || (c != d);
  endfunction

  // Reference: walk the run cycle by cycle using the documented rules.
  task automatic model(output exp_t e);
    bit covered[16];
    int ec;
    bit fin;
    int n;
    e.err = 8'd0; e.cov = 16'd0; e.pass = 1'b0; e.tmo = 1'b0;
    e.ffv = 1'b0; e.ffvec = 4'd0; e.ffy = 1'b0; e.cycles = 64;
    ec = 0; fin = 0;
    for (int i = 0; i < 16; i++) covered[i] = 0;
    for (int k = 0; k < 64 && !fin; k++) begin
      if (sval[k]) begin
        covered[sv[k]] = 1;
        if (sy[k] !== logic'(gold(sv[k]))) begin
          if (ec < 255) ec++;
          if (!e.ffv) begin e.ffv = 1'b1; e.ffvec = sv[k]; e.ffy = sy[k]; end
        end
      end
      n = 0;
      for (int i = 0; i < 16; i++) n += covered[i];
      if (n == 16) begin
        fin = 1; e.pass = (ec == 0); e.cycles = k + 1;
      end else if (k == 63) begin
        fin = 1; e.tmo = 1'b1; e.cycles = 64;
      end
    end
    e.err = ec[7:0];
    for (int i = 0; i < 16; i++) e.cov[i] = covered[i];
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 64; i++) begin sv[i] = 4'd0; sy[i] = 1'b0; sval[i] = 0; end
  endtask

  task automatic fill_exhaustive();
    clear_seq();
    for (int i = 0; i < 16; i++) begin sv[i] = i[3:0]; sy[i] = gold(i[3:0]); sval[i] = 1; end
  endtask

  // Issue one run: queue the prediction, then drive start and the samples.
  task automatic run_seq(input bit noise);
    exp_t e;
    model(e);
    sb_q.push_back(e);
    last_e = e;
    @(negedge clock);
    start = 1'b1; smp_valid = 1'b1; smp_vec = 4'hC; smp_y = 1'b0;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < e.cycles; k++) begin
      smp_valid = sval[k]; smp_vec = sv[k]; smp_y = sy[k];
      start = noise && ($urandom_range(0, 3) == 0);
      @(negedge clock);
    end
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      smp_valid = 1'b1; smp_vec = 4'(j + 3); smp_y = ~gold(4'(j + 3));
      @(negedge clock);
    end
    smp_valid = 1'b0;
    chk("hold_err", {24'd0, err_count}, {24'd0, last_e.err});
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("sb_drain", sb_q.size(), 32'd0);
    while (sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  // Monitor: compare the queued prediction when a run closes.
  always @(negedge clock) begin
    if (!reset_n) begin
      busy_cnt = 0;
      done_q = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !done_q) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("err_count", {24'd0, err_count}, {24'd0, mon_e.err});
          chk("cov_map", {16'd0, cov_map}, {16'd0, mon_e.cov});
          chk("pass", {31'd0, pass}, {31'd0, mon_e.pass});
          chk("timeout", {31'd0, timeout}, {31'd0, mon_e.tmo});
          chk("ff_valid", {31'd0, ff_valid}, {31'd0, mon_e.ffv});
          if (mon_e.ffv) begin
            chk("ff_vec", {28'd0, ff_vec}, {28'd0, mon_e.ffvec});
            chk("ff_y", {31'd0, ff_y}, {31'd0, mon_e.ffy});
          end
          chk("busy_excl", {31'd0, busy}, 32'd0);
          chk("run_cycles", busy_cnt, mon_e.cycles);
        end
        busy_cnt = 0;
      end
      done_q = done;
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; smp_valid = 1'b0; smp_vec = 4'd0; smp_y = 1'b0;
    s1_start = 1'b0; s1_valid = 1'b0; s1_vec = 4'd0; s1_y = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    chk("rst_cov", {16'd0, cov_map}, 32'd0);
    chk("rst_ffv", {31'd0, ff_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    fill_exhaustive(); run_seq(0);
    fill_exhaustive(); sy[12] = 1'b0; run_seq(0);
    clear_seq();
    for (int i = 0; i < 4; i++) begin sv[i] = i[3:0]; sy[i] = gold(i[3:0]); sval[i] = 1; end
    sv[4] = 4'd3; sy[4] = 1'b1; sval[4] = 1; sy[3] = 1'b1;
    for (int i = 4; i < 16; i++) begin sv[i + 1] = i[3:0]; sy[i + 1] = gold(i[3:0]); sval[i + 1] = 1; end
    sy[6] = 1'b0;
    run_seq(0);
    fill_exhaustive(); sval[15] = 0; run_seq(0);
    fill_exhaustive(); sy[6] = 1'bx; run_seq(1);
    for (int r = 0; r < 5; r++) begin
      clear_seq();
      for (int i = 0; i < 64; i++) begin
        sv[i] = 4'($urandom_range(0, 15));
        sval[i] = ($urandom_range(0, 9) < 8);
        sy[i] = ($urandom_range(0, 19) == 0) ? ~gold(sv[i]) : gold(sv[i]);
      end
      if (r < 2) for (int i = 0; i < 16; i++) begin sv[20 + i] = i[3:0]; sval[20 + i] = 1; end
      run_seq(r[0]);
    end

    fill_exhaustive();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp_valid = 1'b1; smp_vec = sv[k]; smp_y = ~sy[k];
      @(negedge clock);
    end
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {24'd0, err_count}, 32'd0);
    chk("mid_rst_cov", {16'd0, cov_map}, 32'd0);
    chk("mid_rst_ffv", {31'd0, ff_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp_valid = 1'b1; smp_vec = 4'(k); smp_y = ~gold(4'(k));
      @(negedge clock);
    end
    smp_valid = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_err", {24'd0, err_count}, 32'd0);
    chk("idle_cov", {16'd0, cov_map}, 32'd0);

    s1_start = 1'b1;
    @(negedge clock);
    s1_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s1_valid = 1'b1; s1_vec = i[3:0];
      s1_y = (i < 5) ? ~gold(i[3:0]) : gold(i[3:0]);
      @(negedge clock);
    end
    s1_valid = 1'b0;
    begin
      int w;
      w = 0;
      while (!d1 && w < 20) begin @(negedge clock); w++; end
    end
    chk("sat_done", {31'd0, d1}, 32'd1);
    chk("sat_err", {30'd0, e1}, 32'd3);
    chk("sat_pass", {31'd0, p1}, 32'd0);
    chk("sat_ffvec", {28'd0, fvec1}, 32'd0);
    s1_start = 1'b1;
    @(negedge clock);
    s1_start = 1'b0;
    chk("restart_busy", {31'd0, b1}, 32'd1);
    chk("restart_done", {31'd0, d1}, 32'd0);
    chk("restart_err", {30'd0, e1}, 32'd0);
    chk("restart_cov", {16'd0, c1}, 32'd0);
    chk("restart_ffv", {31'd0, fv1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
